subbyte_serial_sequencer: RTL

Serial SubBytes controller for the area-optimised AES round. It accepts a 128-bit AES state over a valid/ready handshake and streams its 16 bytes, one per cycle, through a single shared byte-substitution datapath (the composite-field GF((2^4)^2) S-box built on the GF(2^4) inversion stage). It then reassembles the returned bytes into a 128-bit result and presents it downstream with its own valid/ready handshake. The S-box itself stays outside the block and connects through a byte-wide issue/return port pair with a fixed, parameterised latency.

---
 rtl/subbyte_serial_sequencer_if.sv | 37 +++
 rtl/subbyte_serial_sequencer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/subbyte_serial_sequencer_if.sv
// -----------------------------------------------------------------------------
// subbyte_serial_sequencer_if
// Handshake and S-box port bundle for the serial SubBytes sequencer.
//   slave  : the sequencer side (consumes i_*, drives o_*)
//   master : the surrounding round logic / external S-box side
// Signals
//   i_valid / o_ready       upstream handshake, i_state is the 128-bit input state
//   o_sub_byte / o_sub_valid byte issued to the shared S-box
//   i_sub_byte              S-box result, returned a fixed latency later
//   o_state / o_valid / i_ready downstream handshake
//   o_busy                  sequencer is not idle
// -----------------------------------------------------------------------------
interface subbyte_serial_sequencer_if #(
    parameter int NB_BYTE = 8,
    parameter int N_BYTES = 16
);
    logic                         i_valid;
    logic                         o_ready;
    logic [NB_BYTE*N_BYTES-1:0]   i_state;
    logic [NB_BYTE-1:0]           o_sub_byte;
    logic                         o_sub_valid;
    logic [NB_BYTE-1:0]           i_sub_byte;
    logic [NB_BYTE*N_BYTES-1:0]   o_state;
    logic                         o_valid;
    logic                         i_ready;
    logic                         o_busy;

    modport slave (
        input  i_valid, i_state, i_sub_byte, i_ready,
        output o_ready, o_sub_byte, o_sub_valid, o_state, o_valid, o_busy
    );

    modport master (
        output i_valid, i_state, i_sub_byte, i_ready,
        input  o_ready, o_sub_byte, o_sub_valid, o_state, o_valid, o_busy
    );
endinterface

// File: rtl/subbyte_serial_sequencer.sv
// -----------------------------------------------------------------------------
// subbyte_serial_sequencer
// Streams the 16 bytes of an AES state through one shared external S-box, one
// byte per cycle, and reassembles the substituted bytes into a 128-bit result.
// Ports
//   i_clock    rising-edge clock
//   i_reset_n  asynchronous active-low reset
//   bus        subbyte_serial_sequencer_if.slave (handshakes + S-box port)
// Parameters
//   NB_BYTE (8 only), N_BYTES (16 only), SUB_LATENCY (S-box depth, 0..4)
//
// state | meaning
// IDLE  | ready for a new state, nothing in flight
// ISSUE | driving captured byte[issue_cnt] to the S-box
// DRAIN | all bytes issued, collecting outstanding returns
// DONE  | result presented downstream until i_ready
// -----------------------------------------------------------------------------
module subbyte_serial_sequencer #(
    parameter int NB_BYTE     = 8,
    parameter int N_BYTES     = 16,
    parameter int SUB_LATENCY = 2
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    subbyte_serial_sequencer_if.slave bus
);
    localparam int                NB_STATE = NB_BYTE * N_BYTES;
    localparam int                NB_CNT   = $clog2(N_BYTES);
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(N_BYTES - 1);
    localparam logic [NB_CNT-1:0] CNT_ONE  = NB_CNT'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [NB_STATE-1:0] in_reg;
    logic [NB_STATE-1:0] res_reg;
    logic [NB_CNT-1:0]   issue_cnt;
    logic [NB_CNT-1:0]   rx_cnt;
    logic                accept;
    logic                sub_valid;
    logic [NB_BYTE-1:0]  sub_byte;
    logic                ret_valid;

    assign accept = (state == IDLE) && bus.i_valid;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        sub_valid  = 1'b0;
        sub_byte   = '0;
        case (state)
            IDLE: begin
                if (bus.i_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                sub_valid = 1'b1;
                sub_byte  = in_reg[int'(issue_cnt) * NB_BYTE +: NB_BYTE];
                // A zero-latency S-box returns the last byte in this same
                // cycle, so there is nothing left to drain.
                if (issue_cnt == CNT_LAST) begin
                    state_next = (SUB_LATENCY == 0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (ret_valid && (rx_cnt == CNT_LAST)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.i_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Return-valid tracking: a copy of the issue strobe delayed by the S-box
    // depth. Clearing it on reset is what discards returns still in flight.
    generate
        if (SUB_LATENCY == 0) begin : g_comb_ret
            assign ret_valid = sub_valid;
        end else begin : g_ret_pipe
            logic [SUB_LATENCY-1:0] vld_sr;

            always_ff @(posedge i_clock or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    vld_sr <= '0;
                end else begin
                    vld_sr[0] <= sub_valid;
                    for (int i = 1; i < SUB_LATENCY; i++) begin
                        vld_sr[i] <= vld_sr[i-1];
                    end
                end
            end

            assign ret_valid = vld_sr[SUB_LATENCY-1];
        end
    endgenerate

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            in_reg    <= '0;
            res_reg   <= '0;
            issue_cnt <= '0;
            rx_cnt    <= '0;
        end else if (accept) begin
            in_reg    <= bus.i_state;
            issue_cnt <= '0;
            rx_cnt    <= '0;
        end else begin
            if (sub_valid) begin
                issue_cnt <= issue_cnt + CNT_ONE;
            end
            if (ret_valid) begin
                res_reg[int'(rx_cnt) * NB_BYTE +: NB_BYTE] <= bus.i_sub_byte;
                rx_cnt <= rx_cnt + CNT_ONE;
            end
        end
    end

    assign bus.o_ready     = (state == IDLE);
    assign bus.o_busy      = (state != IDLE);
    assign bus.o_valid     = (state == DONE);
    assign bus.o_sub_valid = sub_valid;
    assign bus.o_sub_byte  = sub_byte;
    assign bus.o_state     = res_reg;
endmodule
